// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   state_e : arbiter FSM states (idle, executing, holding a response)
//   Op*     : ALU opcode constants carried unchanged on reqN_sel
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic [3:0] OpPassB = 4'd0;
    localparam logic [3:0] OpNot   = 4'd1;
    localparam logic [3:0] OpAnd   = 4'd2;
    localparam logic [3:0] OpOr    = 4'd3;
    localparam logic [3:0] OpXor   = 4'd4;
    localparam logic [3:0] OpShl   = 4'd7;
    localparam logic [3:0] OpShr   = 4'd8;
    localparam logic [3:0] OpSra   = 4'd9;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters and the ALU arbiter.
//   reqN_valid/ready/sel/a/b : request handshake and payload per requester
//   rspN_valid/ready         : response handshake per requester
//   rsp_c, rsp_cmp           : shared result bus and compare flag
//   busy                     : arbiter is not idle
// slave modport is the arbiter side, master modport the requester side.
interface alu_arbiter_if;

    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_sel;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_sel;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic       rsp0_valid;
    logic       rsp0_ready;
    logic       rsp1_valid;
    logic       rsp1_ready;
    logic [7:0] rsp_c;
    logic       rsp_cmp;
    logic       busy;

    modport slave (
        input  req0_valid, req0_sel, req0_a, req0_b,
        input  req1_valid, req1_sel, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_c, rsp_cmp, busy
    );

    modport master (
        output req0_valid, req0_sel, req0_a, req0_b,
        output req1_valid, req1_sel, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_c, rsp_cmp, busy
    );

endinterface

// File: rtl/ALU8bit.sv
// Combinational 8-bit ALU.
//   sel_i : opcode (unused codes produce c_o = 0)
//   a_i   : operand A
//   b_i   : operand B (shift amount in B[2:0] for shift opcodes)
//   c_o   : result
//   cmp_o : unsigned A > B
module ALU8bit
    import alu_arbiter_pkg::*;
(
    input  logic [3:0] sel_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] c_o,
    output logic       cmp_o
);

    always_comb begin
        c_o = 8'h00;
        case (sel_i)
            OpPassB: c_o = b_i;
            OpNot:   c_o = ~b_i;
            OpAnd:   c_o = a_i & b_i;
            OpOr:    c_o = a_i | b_i;
            OpXor:   c_o = a_i ^ b_i;
            OpShl:   c_o = a_i << b_i[2:0];
            OpShr:   c_o = a_i >> b_i[2:0];
            OpSra:   c_o = $signed(a_i) >>> b_i[2:0];
            default: c_o = 8'h00;
        endcase
    end

    assign cmp_o = (a_i > b_i);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU8bit between two requesters.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : request/response handshakes and shared result (slave side)
// One operation in flight: IDLE accepts, EXEC computes and latches the result,
// RESP holds it until the owner consumes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_arbiter_if.slave   bus
);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] sel_q, sel_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] rsp_c_q, rsp_c_d;
    logic       rsp_cmp_q, rsp_cmp_d;

    logic       grant;
    logic       rdy0, rdy1;
    logic [7:0] alu_c;
    logic       alu_cmp;

    ALU8bit u_alu (
        .sel_i (sel_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .c_o   (alu_c),
        .cmp_o (alu_cmp)
    );

    // On a tie the requester that was not served last wins.
    assign grant = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    assign rdy0  = (state_q == StIdle) && bus.req0_valid && !grant;
    assign rdy1  = (state_q == StIdle) && bus.req1_valid && grant;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_c_d      = rsp_c_q;
        rsp_cmp_d    = rsp_cmp_q;
        case (state_q)
            StIdle: begin
                if (rdy0 || rdy1) begin
                    owner_d = grant;
                    sel_d   = grant ? bus.req1_sel : bus.req0_sel;
                    a_d     = grant ? bus.req1_a   : bus.req0_a;
                    b_d     = grant ? bus.req1_b   : bus.req0_b;
                    state_d = StExec;
                end
            end
            StExec: begin
                rsp_c_d   = alu_c;
                rsp_cmp_d = alu_cmp;
                state_d   = StResp;
            end
            StResp: begin
                // Only the owner's ready can retire the response.
                if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
                    last_grant_d = owner_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= ~PRIO_INIT;
            sel_q        <= 4'h0;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            rsp_c_q      <= 8'h00;
            rsp_cmp_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_c_q      <= rsp_c_d;
            rsp_cmp_q    <= rsp_cmp_d;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rsp0_valid = (state_q == StResp) && !owner_q;
    assign bus.rsp1_valid = (state_q == StResp) && owner_q;
    assign bus.rsp_c      = rsp_c_q;
    assign bus.rsp_cmp    = rsp_cmp_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (PRIO_INIT = 0).
module tb_alu_arbiter;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   chk_cnt;

    alu_arbiter_if bus ();

    alu_arbiter #(
        .PRIO_INIT (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag, input logic [7:0] c_exp,
                                      input logic cmp_exp);
        check({tag, " busy"}, {7'd0, bus.busy}, 8'd0);
        check({tag, " rsp0_valid"}, {7'd0, bus.rsp0_valid}, 8'd0);
        check({tag, " rsp1_valid"}, {7'd0, bus.rsp1_valid}, 8'd0);
        check({tag, " rsp_c"}, bus.rsp_c, c_exp);
        check({tag, " rsp_cmp"}, {7'd0, bus.rsp_cmp}, {7'd0, cmp_exp});
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        rst_n    = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_sel = 4'h0; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_sel = 4'h0; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Reset state
        cyc();
        cyc();
        check_idle_outputs("reset", 8'h00, 1'b0);
        check("reset req0_ready", {7'd0, bus.req0_ready}, 8'd0);
        check("reset req1_ready", {7'd0, bus.req1_ready}, 8'd0);
        rst_n = 1'b1;
        cyc();

        // req0 alone: AND F3 & 25 = 21, F3 > 25
        bus.req0_valid = 1'b1; bus.req0_sel = 4'd2; bus.req0_a = 8'hF3; bus.req0_b = 8'h25;
        #1;
        check("and req0_ready", {7'd0, bus.req0_ready}, 8'd1);
        check("and req1_ready", {7'd0, bus.req1_ready}, 8'd0);
        cyc();
        bus.req0_valid = 1'b0;
        #1;
        check("and exec busy", {7'd0, bus.busy}, 8'd1);
        check("and exec rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd0);
        cyc();
        check("and rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd1);
        check("and rsp1_valid", {7'd0, bus.rsp1_valid}, 8'd0);
        check("and rsp_c", bus.rsp_c, 8'h21);
        check("and rsp_cmp", {7'd0, bus.rsp_cmp}, 8'd1);
        bus.rsp0_ready = 1'b1;
        cyc();
        bus.rsp0_ready = 1'b0;
        check_idle_outputs("and done", 8'h21, 1'b1);

        // Fresh reset, then a tie: req0 (SHL) first, then req1 (SRA)
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        bus.req0_valid = 1'b1; bus.req0_sel = 4'd7; bus.req0_a = 8'hA3; bus.req0_b = 8'h02;
        bus.req1_valid = 1'b1; bus.req1_sel = 4'd9; bus.req1_a = 8'hA3; bus.req1_b = 8'h02;
        #1;
        check("tie1 req0_ready", {7'd0, bus.req0_ready}, 8'd1);
        check("tie1 req1_ready", {7'd0, bus.req1_ready}, 8'd0);
        cyc();
        check("tie1 exec req0_ready", {7'd0, bus.req0_ready}, 8'd0);
        check("tie1 exec req1_ready", {7'd0, bus.req1_ready}, 8'd0);
        cyc();
        check("shl rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd1);
        check("shl rsp1_valid", {7'd0, bus.rsp1_valid}, 8'd0);
        check("shl rsp_c", bus.rsp_c, 8'h8C);
        bus.rsp0_ready = 1'b1;
        cyc();
        bus.rsp0_ready = 1'b0;
        #1;
        check("tie2 req0_ready", {7'd0, bus.req0_ready}, 8'd0);
        check("tie2 req1_ready", {7'd0, bus.req1_ready}, 8'd1);
        cyc();
        cyc();
        check("sra rsp1_valid", {7'd0, bus.rsp1_valid}, 8'd1);
        check("sra rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd0);
        check("sra rsp_c", bus.rsp_c, 8'hE8);
        check("sra rsp_cmp", {7'd0, bus.rsp_cmp}, 8'd1);

        // Backpressure on rsp1 with a stray rsp0_ready that must be ignored
        bus.rsp0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp rsp1_valid", {7'd0, bus.rsp1_valid}, 8'd1);
            check("bp rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd0);
            check("bp rsp_c", bus.rsp_c, 8'hE8);
            check("bp rsp_cmp", {7'd0, bus.rsp_cmp}, 8'd1);
            check("bp busy", {7'd0, bus.busy}, 8'd1);
            check("bp req0_ready", {7'd0, bus.req0_ready}, 8'd0);
            check("bp req1_ready", {7'd0, bus.req1_ready}, 8'd0);
        end
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b1;
        cyc();
        bus.rsp1_ready = 1'b0;
        #1;
        check("tie3 req0_ready", {7'd0, bus.req0_ready}, 8'd1);
        check("tie3 req1_ready", {7'd0, bus.req1_ready}, 8'd0);
        // Withdraw both before any edge: nothing may be accepted
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check("withdraw req0_ready", {7'd0, bus.req0_ready}, 8'd0);
        cyc();
        check_idle_outputs("withdraw", 8'hE8, 1'b1);

        // Reset pulse while in EXEC discards the SHR operation
        bus.req0_valid = 1'b1; bus.req0_sel = 4'd8; bus.req0_a = 8'hA3; bus.req0_b = 8'h02;
        cyc();
        bus.req0_valid = 1'b0;
        check("rst exec busy", {7'd0, bus.busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst async", 8'h00, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check_idle_outputs("rst after", 8'h00, 1'b0);

        // Retry SHR; payload edits while not ready must not affect it
        bus.req0_valid = 1'b1;
        cyc();
        bus.req0_sel = 4'd0; bus.req0_b = 8'hFF;
        cyc();
        check("shr rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd1);
        check("shr rsp_c", bus.rsp_c, 8'h28);
        check("shr rsp_cmp", {7'd0, bus.rsp_cmp}, 8'd1);
        bus.req0_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        cyc();
        bus.rsp0_ready = 1'b0;
        check_idle_outputs("shr done", 8'h28, 1'b1);

        // PASS_B then NOT back-to-back at the minimum issue interval
        bus.req0_valid = 1'b1; bus.req0_sel = 4'd0; bus.req0_a = 8'h03; bus.req0_b = 8'h0C;
        bus.rsp0_ready = 1'b1;
        #1;
        check("passb req0_ready", {7'd0, bus.req0_ready}, 8'd1);
        cyc();
        bus.req0_sel = 4'd1;
        #1;
        check("passb exec req0_ready", {7'd0, bus.req0_ready}, 8'd0);
        cyc();
        check("passb rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd1);
        check("passb rsp_c", bus.rsp_c, 8'h0C);
        check("passb rsp_cmp", {7'd0, bus.rsp_cmp}, 8'd0);
        check("passb resp req0_ready", {7'd0, bus.req0_ready}, 8'd0);
        cyc();
        check("not req0_ready", {7'd0, bus.req0_ready}, 8'd1);
        cyc();
        bus.req0_valid = 1'b0;
        cyc();
        check("not rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd1);
        check("not rsp_c", bus.rsp_c, 8'hF3);
        cyc();
        bus.rsp0_ready = 1'b0;
        check_idle_outputs("not done", 8'hF3, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
